// File: rtl/pipe_pkg.sv
// Shared widths, register-zero constant and forwarding codes for the
// write-back / decode operand path.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RN_W   = 5;

    localparam logic [RN_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_EALU = 2'b01,
        FWD_MALU = 2'b10,
        FWD_MMO  = 2'b11
    } fwd_t;

    // Priority: E-stage ALU result, then M-stage ALU result, then M-stage load
    // data; a load still in E cannot be forwarded and is covered by the stall.
    function automatic fwd_t fwd_sel(
        input logic [RN_W-1:0] src,
        input logic            ewreg,
        input logic            em2reg,
        input logic [RN_W-1:0] ern,
        input logic            mwreg,
        input logic            mm2reg,
        input logic [RN_W-1:0] mrn
    );
        fwd_t sel;
        sel = FWD_RF;
        if (src != REG_ZERO) begin
            if (ewreg && (ern == src) && !em2reg)
                sel = FWD_EALU;
            else if (mwreg && (mrn == src))
                sel = mm2reg ? FWD_MMO : FWD_MALU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile32.sv
// 32x32 register file: entry 0 hard-wired to zero, synchronous clear,
// one write port and two combinational read ports with write-through.
module regfile32
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [RN_W-1:0]   wn,
    input  logic [DATA_W-1:0] wd,
    input  logic [RN_W-1:0]   ra,
    input  logic [RN_W-1:0]   rb,
    output logic [DATA_W-1:0] qa,
    output logic [DATA_W-1:0] qb
);

    logic [DATA_W-1:0] rf_reg [32];
    logic              wr_en;

    assign wr_en = we && (wn != REG_ZERO);

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                always_ff @(posedge clock) begin
                    rf_reg[gi] <= '0;
                end
            end else begin : g_reg
                always_ff @(posedge clock) begin
                    if (!resetn)
                        rf_reg[gi] <= '0;
                    else if (wr_en && (wn == RN_W'(gi)))
                        rf_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    // Write-through lets decode see the value W is committing this cycle.
    always_comb begin
        qa = rf_reg[ra];
        qb = rf_reg[rb];
        if (wr_en && (wn == ra)) qa = wd;
        if (wr_en && (wn == rb)) qb = wd;
        if (ra == REG_ZERO) qa = '0;
        if (rb == REG_ZERO) qb = '0;
    end

endmodule

// File: rtl/pipe_wb_regfile.sv
// Write-back mux, register file and decode-stage operand forwarding with
// load-use stall detection.
module pipe_wb_regfile
    import pipe_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              wwreg,
    input  logic              wm2reg,
    input  logic [DATA_W-1:0] wmo,
    input  logic [DATA_W-1:0] walu,
    input  logic [RN_W-1:0]   wrn,
    input  logic              mwreg,
    input  logic              mm2reg,
    input  logic [DATA_W-1:0] mmo,
    input  logic [DATA_W-1:0] malu,
    input  logic [RN_W-1:0]   mrn,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic [DATA_W-1:0] ealu,
    input  logic [RN_W-1:0]   ern,
    input  logic [RN_W-1:0]   rs,
    input  logic [RN_W-1:0]   rt,
    input  logic              users,
    input  logic              usert,
    output logic [DATA_W-1:0] wdi,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    output logic [1:0]        fwda,
    output logic [1:0]        fwdb,
    output logic              stall
);

    logic [DATA_W-1:0] rf_q [2];
    logic [RN_W-1:0]   src [2];
    logic [DATA_W-1:0] opnd [2];
    fwd_t              sel [2];

    assign wdi    = wm2reg ? wmo : walu;
    assign src[0] = rs;
    assign src[1] = rt;

    regfile32 u_rf (
        .clock  (clock),
        .resetn (resetn),
        .we     (wwreg),
        .wn     (wrn),
        .wd     (wdi),
        .ra     (rs),
        .rb     (rt),
        .qa     (rf_q[0]),
        .qb     (rf_q[1])
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            assign sel[gi] = fwd_sel(src[gi], ewreg, em2reg, ern, mwreg, mm2reg, mrn);

            always_comb begin
                opnd[gi] = rf_q[gi];
                case (sel[gi])
                    FWD_EALU: opnd[gi] = ealu;
                    FWD_MALU: opnd[gi] = malu;
                    FWD_MMO:  opnd[gi] = mmo;
                    default:  opnd[gi] = rf_q[gi];
                endcase
            end
        end
    endgenerate

    assign da   = opnd[0];
    assign db   = opnd[1];
    assign fwda = sel[0];
    assign fwdb = sel[1];

    assign stall = ewreg && em2reg && (ern != REG_ZERO) &&
                   ((users && (ern == rs)) || (usert && (ern == rt)));

endmodule
